// File: rtl/rh_gpv_drive_sched_if.sv
// Request/response bundle between the drive sequencers and the GPV scheduler.
// Requester i occupies slice i of every packed req_* field.
interface rh_gpv_drive_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int VEC_W   = 64,
    parameter int DATA_W  = 32,
    parameter int POS_W   = 6,
    parameter int LEN_W   = 6,
    parameter int DLY_W   = 8,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*POS_W-1:0]  req_pos;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*DLY_W-1:0]  req_delay;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      busy;
    logic                      done;
    logic [ID_W-1:0]           done_id;
    logic [VEC_W-1:0]          vector_out;

    modport master (
        output req_valid, req_pos, req_len, req_data, req_delay,
        input  req_ready, busy, done, done_id, vector_out
    );

    modport slave (
        input  req_valid, req_pos, req_len, req_data, req_delay,
        output req_ready, busy, done, done_id, vector_out
    );
endinterface

// File: rtl/rh_gpv_drive_sched.sv
// Round-robin scheduler that applies one delayed bit-field write at a time
// onto a registered general-purpose output vector.
module rh_gpv_drive_sched #(
    parameter int               NUM_REQ   = 4,
    parameter int               VEC_W     = 64,
    parameter int               DATA_W    = 32,
    parameter int               POS_W     = 6,
    parameter int               LEN_W     = 6,
    parameter int               DLY_W     = 8,
    parameter logic [VEC_W-1:0] RESET_VAL = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    rh_gpv_drive_sched_if.slave  bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, APPLY} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    win_id;
    logic               win_found;
    logic               hs;
    logic [POS_W-1:0]   pos_q;
    logic [LEN_W-1:0]   len_q;
    logic [DATA_W-1:0]  data_q;
    logic [DLY_W-1:0]   cnt_q;
    logic [ID_W-1:0]    id_q;
    logic [DLY_W-1:0]   win_delay;
    logic [VEC_W-1:0]   vec_q;
    logic               done_q;
    logic [ID_W-1:0]    done_id_q;

    // Lengths above the field width behave as a full-width write.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len;
    endfunction

    // Overlay data[len-1:0] at bit pos; the shift happens in VEC_W bits so
    // anything past the top of the vector falls off instead of wrapping.
    function automatic logic [VEC_W-1:0] merge_field(
        input logic [VEC_W-1:0]  vec,
        input logic [POS_W-1:0]  pos,
        input logic [LEN_W-1:0]  len,
        input logic [DATA_W-1:0] data
    );
        logic [DATA_W-1:0] fmask;
        logic [VEC_W-1:0]  wmask;
        logic [VEC_W-1:0]  wdata;
        fmask = ~({DATA_W{1'b1}} << len);
        wmask = VEC_W'(fmask) << pos;
        wdata = VEC_W'(data & fmask) << pos;
        return (vec & ~wmask) | wdata;
    endfunction

    // Round-robin pick: first valid requester scanning upward from ptr.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign hs        = (state_q == IDLE) && win_found && !reset;
    assign win_delay = bus.req_delay[win_id*DLY_W +: DLY_W];

    // Grant is only offered while idle and never while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (hs) begin
            bus.req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
        end
    end

    // Next-state logic for the IDLE -> WAIT -> APPLY sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = (win_delay != '0) ? WAIT : APPLY;
            WAIT:    if (cnt_q == DLY_W'(1)) state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state, round-robin pointer and the driven vector.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            vec_q     <= RESET_VAL;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == APPLY);
            if (hs) begin
                ptr_q <= (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
            end
            if (state_q == APPLY) begin
                vec_q     <= merge_field(vec_q, pos_q, len_q, data_q);
                done_id_q <= id_q;
            end
        end
    end

    // Request fields captured at the handshake and the wait countdown.
    always_ff @(posedge clock) begin
        if (hs) begin
            pos_q  <= bus.req_pos[win_id*POS_W +: POS_W];
            len_q  <= clamp_len(bus.req_len[win_id*LEN_W +: LEN_W]);
            data_q <= bus.req_data[win_id*DATA_W +: DATA_W];
            cnt_q  <= win_delay;
            id_q   <= win_id;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - DLY_W'(1);
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.done_id    = done_id_q;
    assign bus.vector_out = vec_q;
endmodule

// File: tb/tb_rh_gpv_drive_sched.sv
// Directed bench for rh_gpv_drive_sched with hand-computed expectations.
module tb_rh_gpv_drive_sched;
    localparam int NUM_REQ = 4;
    localparam int VEC_W   = 64;
    localparam int DATA_W  = 32;
    localparam int POS_W   = 6;
    localparam int LEN_W   = 6;
    localparam int DLY_W   = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    rh_gpv_drive_sched_if #(
        .NUM_REQ(NUM_REQ), .VEC_W(VEC_W), .DATA_W(DATA_W),
        .POS_W(POS_W), .LEN_W(LEN_W), .DLY_W(DLY_W)
    ) bus_if ();

    rh_gpv_drive_sched #(
        .NUM_REQ(NUM_REQ), .VEC_W(VEC_W), .DATA_W(DATA_W),
        .POS_W(POS_W), .LEN_W(LEN_W), .DLY_W(DLY_W), .RESET_VAL('0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input int pos, input int len,
                           input logic [31:0] data, input int dly);
        bus_if.req_pos[i*POS_W +: POS_W]    = POS_W'(pos);
        bus_if.req_len[i*LEN_W +: LEN_W]    = LEN_W'(len);
        bus_if.req_data[i*DATA_W +: DATA_W] = data;
        bus_if.req_delay[i*DLY_W +: DLY_W]  = DLY_W'(dly);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // One full request from a single requester, bounded on both waits.
    task automatic do_req(input int id, input int pos, input int len,
                          input logic [31:0] data, input int dly);
        bit got;
        set_req(id, pos, len, data, dly);
        bus_if.req_valid = NUM_REQ'(1) << id;
        #1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (bus_if.req_ready[id]) got = 1;
            else tick();
        end
        if (!got) check("hs_timeout", 0, 1);
        tick();
        bus_if.req_valid = '0;
        got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            if (bus_if.done) got = 1;
            else tick();
        end
        if (!got) check("done_timeout", 0, 1);
        check("req_done_id", 64'(bus_if.done_id), 64'(id));
        tick();
    endtask

    initial begin
        int dones;
        bus_if.req_valid = '0;
        bus_if.req_pos   = '0;
        bus_if.req_len   = '0;
        bus_if.req_data  = '0;
        bus_if.req_delay = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_vec",   bus_if.vector_out, 64'h0);
        check("rst_ready", 64'(bus_if.req_ready), 64'h0);
        check("rst_done",  64'(bus_if.done), 64'h0);
        check("rst_busy",  64'(bus_if.busy), 64'h0);
        reset = 1'b0;
        tick();

        // T2: single write, delay 0
        set_req(0, 4, 8, 32'hA5, 0);
        bus_if.req_valid = 4'b0001;
        #1;
        check("t2_ready", 64'(bus_if.req_ready), 64'h1);
        tick();
        bus_if.req_valid = '0;
        check("t2_busy", 64'(bus_if.busy), 64'h1);
        check("t2_done_early", 64'(bus_if.done), 64'h0);
        check("t2_vec_early", bus_if.vector_out, 64'h0);
        tick();
        check("t2_vec", bus_if.vector_out, 64'h0000_0000_0000_0A50);
        check("t2_done", 64'(bus_if.done), 64'h1);
        check("t2_done_id", 64'(bus_if.done_id), 64'h0);
        check("t2_busy_end", 64'(bus_if.busy), 64'h0);
        tick();
        check("t2_done_pulse", 64'(bus_if.done), 64'h0);

        // T1: async reset mid-cycle with a valid request pending
        bus_if.req_valid = 4'b0001;
        #2 reset = 1'b1;
        #1;
        check("t1_vec",   bus_if.vector_out, 64'h0);
        check("t1_ready", 64'(bus_if.req_ready), 64'h0);
        check("t1_done",  64'(bus_if.done), 64'h0);
        bus_if.req_valid = '0;
        @(posedge clock);
        #1 reset = 1'b0;

        // T3: all requesters valid, round-robin 0,1,2,3,0,1
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i * 8, 4, 32'(i + 1), 0);
        bus_if.req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 12; n++) begin
            if (n % 2 == 0) begin
                check("t3_ready", 64'(bus_if.req_ready), 64'(1 << ((n / 2) % 4)));
                if (n > 0) begin
                    check("t3_done", 64'(bus_if.done), 64'h1);
                    check("t3_done_id", 64'(bus_if.done_id), 64'(((n / 2) - 1) % 4));
                end
            end else begin
                check("t3_ready_busy", 64'(bus_if.req_ready), 64'h0);
            end
            tick();
        end
        bus_if.req_valid = '0;
        check("t3_last_done", 64'(bus_if.done), 64'h1);
        check("t3_last_id", 64'(bus_if.done_id), 64'h1);
        tick();
        check("t3_vec", bus_if.vector_out, 64'h0000_0000_0403_0201);

        // T4: delayed write from requester 2 while requester 0 waits
        do_reset();
        set_req(2, 32, 4, 32'hC, 3);
        bus_if.req_valid = 4'b0100;
        #1;
        check("t4_ready", 64'(bus_if.req_ready), 64'h4);
        tick();
        set_req(0, 0, 0, 32'hFF, 0);
        bus_if.req_valid = 4'b0001;
        #1;
        for (int s = 1; s <= 4; s++) begin
            check("t4_busy", 64'(bus_if.busy), 64'h1);
            check("t4_ready_busy", 64'(bus_if.req_ready), 64'h0);
            check("t4_no_done", 64'(bus_if.done), 64'h0);
            tick();
        end
        check("t4_done", 64'(bus_if.done), 64'h1);
        check("t4_done_id", 64'(bus_if.done_id), 64'h2);
        check("t4_vec", bus_if.vector_out, 64'h0000_000C_0000_0000);
        check("t4_b2b_ready", 64'(bus_if.req_ready), 64'h1);
        tick();
        bus_if.req_valid = '0;
        tick();
        check("t4_len0_done", 64'(bus_if.done), 64'h1);
        check("t4_len0_id", 64'(bus_if.done_id), 64'h0);
        check("t4_len0_vec", bus_if.vector_out, 64'h0000_000C_0000_0000);
        tick();
        check("t4_done_pulse", 64'(bus_if.done), 64'h0);

        // T5: clipping at the top of the vector and length clamping
        do_req(1, 60, 8, 32'hFF, 0);
        check("t5_clip", bus_if.vector_out, 64'hF000_000C_0000_0000);
        do_req(3, 16, 63, 32'hFFFF_FFFF, 0);
        check("t5_clamp", bus_if.vector_out, 64'hF000_FFFF_FFFF_0000);

        // T6: reset during WAIT discards the request
        do_reset();
        set_req(1, 8, 8, 32'hAB, 5);
        bus_if.req_valid = 4'b0010;
        #1;
        tick();
        bus_if.req_valid = '0;
        tick();
        tick();
        check("t6_busy_pre", 64'(bus_if.busy), 64'h1);
        #2 reset = 1'b1;
        #1;
        check("t6_vec", bus_if.vector_out, 64'h0);
        check("t6_busy", 64'(bus_if.busy), 64'h0);
        check("t6_done", 64'(bus_if.done), 64'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus_if.done) dones++;
        end
        check("t6_no_done", 64'(dones), 64'h0);
        check("t6_vec_after", bus_if.vector_out, 64'h0);
        bus_if.req_valid = 4'b1111;
        #1;
        check("t6_ptr_reset", 64'(bus_if.req_ready), 64'h1);
        bus_if.req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
